// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use bubbles, branch flushes and data-memory freezes for the 5-stage core.
// Latency: stall/flush outputs are combinational, same cycle; mem_wait and counters are registered.
// Backpressure: mem_req & ~mem_ready freezes PC..EX/MEM. Optional macro HAZARD_MEM_TIMEOUT_EN adds a WAIT watchdog.
module hazard_ctrl #(
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_Rs1,
    input  logic [4:0]       id_Rs2,
    input  logic             id_use_Rs1,
    input  logic             id_use_Rs2,
    input  logic [4:0]       ex_Rd,
    input  logic             ex_MemRead,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic             mem_wb_flush,
    output logic             mem_wait,
    output logic [CNT_W-1:0] load_use_cnt,
    output logic [CNT_W-1:0] flush_cnt,
`ifdef HAZARD_MEM_TIMEOUT_EN
    output logic             mem_timeout,
`endif
    output logic [CNT_W-1:0] wait_cnt
);

    typedef enum logic {S_RUN, S_WAIT} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t state_q, state_d;
    logic   lu, mw, freeze, flush, bubble;

`ifdef HAZARD_MEM_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};

    logic [TMO_W-1:0] tmo_cnt_q;
    logic             tmo_q;
    logic             tmo_hit;

    assign tmo_hit     = (state_q == S_WAIT) && (tmo_cnt_q == TMO_LAST);
    assign mem_timeout = tmo_q;
`endif

    always_comb begin
        lu = ex_MemRead && (ex_Rd != 5'd0) &&
             ((id_use_Rs1 && (ex_Rd == id_Rs1)) || (id_use_Rs2 && (ex_Rd == id_Rs2)));
`ifdef HAZARD_MEM_TIMEOUT_EN
        // After a timeout the memory is considered dead; stop freezing on it.
        mw = mem_req && !mem_ready && !tmo_q;
`else
        mw = mem_req && !mem_ready;
`endif
        freeze = mw;
        flush  = !mw && ex_branch_taken;
        bubble = !mw && !ex_branch_taken && lu;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:  state_d = mw ? S_WAIT : S_RUN;
            // A dropped mem_req while waiting is treated as completion.
            S_WAIT: state_d = (!mem_req || mem_ready) ? S_RUN : S_WAIT;
            default: state_d = S_RUN;
        endcase
`ifdef HAZARD_MEM_TIMEOUT_EN
        if (tmo_hit) begin
            state_d = S_RUN;
        end
`endif
    end

    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        mem_wb_flush = 1'b0;
        mem_wait     = 1'b0;
        if (!rst) begin
            pc_stall     = freeze || bubble;
            if_id_stall  = freeze || bubble;
            if_id_flush  = flush;
            id_ex_stall  = freeze;
            id_ex_flush  = flush || bubble;
            ex_mem_stall = freeze;
            mem_wb_flush = freeze;
            mem_wait     = (state_q == S_WAIT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_RUN;
            load_use_cnt <= '0;
            flush_cnt    <= '0;
            wait_cnt     <= '0;
        end else begin
            state_q <= state_d;
            if (bubble) load_use_cnt <= load_use_cnt + CNT_ONE;
            if (flush)  flush_cnt    <= flush_cnt + CNT_ONE;
            if (freeze) wait_cnt     <= wait_cnt + CNT_ONE;
        end
    end

`ifdef HAZARD_MEM_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            if (state_d == S_RUN) begin
                tmo_cnt_q <= '0;
            end else if (state_q == S_WAIT) begin
                tmo_cnt_q <= tmo_cnt_q + TMO_ONE;
            end
            if (tmo_hit) begin
                tmo_q <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: single-cycle output vectors plus multi-cycle wait/reset sequences.
module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  id_Rs1, id_Rs2, ex_Rd;
    logic        id_use_Rs1, id_use_Rs2, ex_MemRead, ex_branch_taken, mem_req, mem_ready;
    logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic        ex_mem_stall, mem_wb_flush, mem_wait;
    logic [31:0] load_use_cnt, flush_cnt, wait_cnt;
    logic [6:0]  outs;

    int checks = 0;
    int errors = 0;

    // Output order: pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush
    localparam logic [6:0] O_NONE   = 7'b0000000;
    localparam logic [6:0] O_FREEZE = 7'b1101011;
    localparam logic [6:0] O_FLUSH  = 7'b0010100;
    localparam logic [6:0] O_BUBBLE = 7'b1100100;

    hazard_ctrl #(.CNT_W(32), .TIMEOUT_CYCLES(256)) dut (
        .clk(clk), .rst(rst),
        .id_Rs1(id_Rs1), .id_Rs2(id_Rs2), .id_use_Rs1(id_use_Rs1), .id_use_Rs2(id_use_Rs2),
        .ex_Rd(ex_Rd), .ex_MemRead(ex_MemRead), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush), .ex_mem_stall(ex_mem_stall),
        .mem_wb_flush(mem_wb_flush), .mem_wait(mem_wait),
        .load_use_cnt(load_use_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
    );

    assign outs = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string      name;
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] rd;
        logic       mr, br, mq, my;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                          input logic [4:0] rd, input logic mr, input logic br, input logic mq, input logic my);
        id_Rs1 = rs1; id_Rs2 = rs2; id_use_Rs1 = u1; id_use_Rs2 = u2;
        ex_Rd = rd; ex_MemRead = mr; ex_branch_taken = br; mem_req = mq; mem_ready = my;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        //          name          rs1    rs2   u1 u2  rd    mr br mq my  expected
        tbl[0]  = '{"lu_rs1",     5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 0, 0, O_BUBBLE};
        tbl[1]  = '{"x0",         5'd0, 5'd0, 1, 0, 5'd0, 1, 0, 0, 0, O_NONE};
        tbl[2]  = '{"rs2_unused", 5'd0, 5'd7, 0, 0, 5'd7, 1, 0, 0, 0, O_NONE};
        tbl[3]  = '{"lu_rs2",     5'd3, 5'd7, 0, 1, 5'd7, 1, 0, 0, 0, O_BUBBLE};
        tbl[4]  = '{"no_load",    5'd5, 5'd0, 1, 0, 5'd5, 0, 0, 0, 0, O_NONE};
        tbl[5]  = '{"br_over_lu", 5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 0, 0, O_FLUSH};
        tbl[6]  = '{"frz_over_all",5'd5,5'd0, 1, 0, 5'd5, 1, 1, 1, 0, O_FREEZE};
        tbl[7]  = '{"req_ready",  5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, O_NONE};
        tbl[8]  = '{"ready_only", 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, O_NONE};
        tbl[9]  = '{"rd_mismatch",5'd5, 5'd0, 1, 0, 5'd6, 1, 0, 0, 0, O_NONE};
        tbl[10] = '{"lu_both",    5'd1, 5'd9, 1, 1, 5'd9, 1, 0, 0, 0, O_BUBBLE};
        tbl[11] = '{"br_only",    5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, O_FLUSH};

        rst = 1'b1;
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_outs", {25'd0, outs}, 32'd0);
        chk("rst_mem_wait", {31'd0, mem_wait}, 32'd0);
        chk("rst_lu_cnt", load_use_cnt, 32'd0);
        chk("rst_flush_cnt", flush_cnt, 32'd0);
        chk("rst_wait_cnt", wait_cnt, 32'd0);

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            set_in(tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2, tbl[i].rd,
                   tbl[i].mr, tbl[i].br, tbl[i].mq, tbl[i].my);
            #1;
            chk(tbl[i].name, {25'd0, outs}, {25'd0, tbl[i].exp});
        end

        // Load-use bubble lasts one cycle and counts once
        do_reset();
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 chk("seq_lu_bubble", {25'd0, outs}, {25'd0, O_BUBBLE});
        @(negedge clk);
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 chk("seq_lu_after", {25'd0, outs}, 32'd0);
        chk("seq_lu_cnt", load_use_cnt, 32'd1);

        // Branch wins over load-use
        do_reset();
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        #1 chk("seq_br_flush", {25'd0, outs}, {25'd0, O_FLUSH});
        @(negedge clk);
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("seq_br_flush_cnt", flush_cnt, 32'd1);
        chk("seq_br_lu_cnt", load_use_cnt, 32'd0);

        // Memory wait: 3 frozen cycles, then release (plain, then with a held branch)
        for (int pass = 0; pass < 2; pass++) begin
            logic br;
            br = (pass == 1);
            do_reset();
            for (int c = 1; c <= 3; c++) begin
                set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, br, 1'b1, 1'b0);
                #1;
                chk($sformatf("mw%0d_frz_c%0d", pass, c), {25'd0, outs}, {25'd0, O_FREEZE});
                chk($sformatf("mw%0d_wait_c%0d", pass, c), {31'd0, mem_wait}, (c == 1) ? 32'd0 : 32'd1);
                @(negedge clk);
            end
            set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, br, 1'b1, 1'b1);
            #1;
            chk($sformatf("mw%0d_release", pass), {25'd0, outs}, br ? {25'd0, O_FLUSH} : 32'd0);
            chk($sformatf("mw%0d_wait_c4", pass), {31'd0, mem_wait}, 32'd1);
            @(negedge clk);
            set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            #1;
            chk($sformatf("mw%0d_wait_c5", pass), {31'd0, mem_wait}, 32'd0);
            chk($sformatf("mw%0d_wait_cnt", pass), wait_cnt, 32'd3);
            chk($sformatf("mw%0d_flush_cnt", pass), flush_cnt, br ? 32'd1 : 32'd0);
        end

        // Reset asserted while waiting on memory
        do_reset();
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        #1 chk("rw_in_wait", {31'd0, mem_wait}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rw_outs_in_rst", {25'd0, outs}, 32'd0);
        chk("rw_wait_in_rst", {31'd0, mem_wait}, 32'd0);
        @(negedge clk);
        chk("rw_wait_cnt", wait_cnt, 32'd0);
        chk("rw_flush_cnt", flush_cnt, 32'd0);
        rst = 1'b0;
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 chk("rw_state_run", {31'd0, mem_wait}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV32I core.
- Covers the hazards that EX-stage operand forwarding cannot: load-use dependencies, taken-branch/jump redirects and data-memory wait states.
- Drives stall/flush enables for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Keeps a small run/wait state machine and performance counters.

Parameters:
- CNT_W, 32, width of performance counters
- TIMEOUT_CYCLES, 256, memory-wait watchdog limit (used only with the optional feature)

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous active-high reset
- id_Rs1  input  5  rs1 index of instruction in ID
- id_Rs2  input  5  rs2 index of instruction in ID
- id_use_Rs1  input  1  ID instruction reads rs1
- id_use_Rs2  input  1  ID instruction reads rs2
- ex_Rd  input  5  rd index of instruction in EX
- ex_MemRead  input  1  EX instruction is a load
- ex_branch_taken  input  1  EX resolved taken branch/jump (redirect)
- mem_req  input  1  MEM stage issuing data-memory access
- mem_ready  input  1  data memory completes access this cycle
- pc_stall  output  1  hold PC
- if_id_stall  output  1  hold IF/ID
- if_id_flush  output  1  clear IF/ID to NOP
- id_ex_stall  output  1  hold ID/EX
- id_ex_flush  output  1  load bubble into ID/EX
- ex_mem_stall  output  1  hold EX/MEM
- mem_wb_flush  output  1  load bubble into MEM/WB
- mem_wait  output  1  state == WAIT (debug)
- load_use_cnt  output  CNT_W  load-use bubbles inserted
- flush_cnt  output  CNT_W  branch flushes performed
- wait_cnt  output  CNT_W  cycles spent frozen on memory

Behaviour:
- Reset: state=RUN, all counters 0. While rst=1, every stall/flush output and mem_wait is 0.
- Hazard terms (combinational):
  - lu = ex_MemRead & (ex_Rd!=0) & ((id_use_Rs1 & ex_Rd==id_Rs1) | (id_use_Rs2 & ex_Rd==id_Rs2))
  - mw = mem_req & ~mem_ready
- State machine: RUN, WAIT.
  - RUN -> WAIT when mw=1.
  - WAIT -> RUN on the first cycle with mem_ready=1.
  - WAIT with mem_req dropped is illegal; treat it as ready and return to RUN.
- Outputs are combinational from the inputs, same cycle. Priority is freeze > flush > bubble:
  1. Freeze (mw=1, in either state):
     - pc_stall, if_id_stall, id_ex_stall and ex_mem_stall = 1.
     - mem_wb_flush = 1.
     - All other outputs 0; branch and lu are ignored this cycle.
     - A pending ex_branch_taken stays held in the frozen EX stage and is acted on in the release cycle.
  2. Flush (ex_branch_taken=1, no freeze):
     - if_id_flush = 1 and id_ex_flush = 1.
     - PC is not stalled, so the redirect is taken.
     - lu is ignored because the ID instruction is squashed.
  3. Bubble (lu=1, no freeze, no flush):
     - pc_stall, if_id_stall and id_ex_flush = 1 for exactly the cycle lu holds.
     - lu deasserts naturally the next cycle because EX then holds a bubble, so the bubble lasts 1 cycle.
  4. Otherwise all stall/flush outputs are 0.
- mem_wait = 1 iff state == WAIT (registered, lags mw by one cycle).
- Counters:
  - load_use_cnt increments by 1 per cycle the bubble case is active.
  - flush_cnt increments by 1 per cycle the flush case is active.
  - wait_cnt increments by 1 per cycle the freeze case is active.
  - All wrap modulo 2^CNT_W with no saturation.
- Simultaneous events:
  - A freeze cycle coinciding with a flush or bubble counts only toward wait_cnt.
  - mem_ready=1 in the same cycle as mem_req means no freeze and no WAIT entry.
- rst asserted mid-WAIT returns state to RUN next edge and clears counters. Outputs are forced to 0 during reset.

Optional Feature:
- Macro: HAZARD_MEM_TIMEOUT_EN
- When defined:
  - Adds output mem_timeout (1 bit) and a wait-cycle counter, cleared on entry to RUN.
  - If the counter reaches TIMEOUT_CYCLES while in WAIT, mem_timeout becomes sticky 1 (until rst) and state is forced to RUN.
  - The freeze is then released regardless of mem_ready.
- When not defined: no mem_timeout port and WAIT is held indefinitely until mem_ready.

Test Plan:
- Load-use: ex_MemRead=1, ex_Rd=5, id_Rs1=5, id_use_Rs1=1 for 1 cycle -> pc_stall=if_id_stall=id_ex_flush=1 that cycle only, load_use_cnt=1.
- x0 and unused operand:
  - ex_Rd=0, id_Rs1=0, id_use_Rs1=1 -> no stall.
  - ex_Rd=7, id_Rs2=7, id_use_Rs2=0 -> no stall.
- Branch vs load-use: ex_branch_taken=1 together with the load-use condition -> if_id_flush=id_ex_flush=1, pc_stall=0, flush_cnt=1, load_use_cnt=0.
- Memory wait:
  - mem_req=1, mem_ready=0 for 3 cycles, then ready -> freeze outputs high 3 cycles and mem_wait high cycles 2–4; wait_cnt=3; release cycle shows no freeze.
  - Repeat with ex_branch_taken=1 throughout -> flush asserted only in the release cycle.
- Reset mid-WAIT: rst=1 during an open wait (mem_ready=0) -> all outputs 0, counters 0, mem_wait=0 after the edge.
- (HAZARD_MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4) mem_ready held 0 -> mem_timeout=1 after 4 WAIT cycles, state RUN, mem_timeout stays 1 until rst.
